bcd_time_writer: RTL and testbench
==================================

# bcd_time_writer

Produces the packed 8-digit BCD time word (HH MM SS cc) that the display scanner and BCD segment encoder consume, and lets the user set the time with three push-buttons. It sits between the board buttons and the digit-scanning display path. It is the writer side of the 32-bit digit bus the scanner reads. Runs a 100 Hz time-of-day count in run mode and freezes it for field-by-field editing in set mode.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level (10 ms at 100 MHz).
- `TICK_DIV`, default 1_000_000: clk cycles per centisecond tick (100 Hz at 100 MHz). Minimum 2.
- `clk` input, 1 bit: single system clock; all state on rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `btn_set` input, 1 bit: raw, asynchronous; rising press toggles run/set mode.
- `btn_next` input, 1 bit: raw; press advances the edit cursor (set mode only).
- `btn_inc` input, 1 bit: raw; press increments the field under the cursor (set mode only).
- `digits` output, 32 bits: packed BCD in this order.
  - [31:28] hour tens 0–2, [27:24] hour ones.
  - [23:20] minute tens 0–5, [19:16] minute ones.
  - [15:12] second tens 0–5, [11:8] second ones.
  - [7:4] centisecond tens, [3:0] centisecond ones.
- `set_mode` output, 1 bit: 1 while editing.
- `cursor` output, 2 bits: 0=hours, 1=minutes, 2=seconds. 3 is never driven.
- `day_wrap` output, 1 bit: one-cycle pulse on rollover 23:59:59.99 → 00:00:00.00.

## Operation
- Reset values (asynchronous):
  - digits = 32'h0000_0000, set_mode = 0, cursor = 0, day_wrap = 0.
  - Divider, debounce counters and synchronizers cleared.
- Button conditioning, per button:
  - 2-FF synchronizer.
  - Debounce counter: resets on any change of the synchronized level. When it reaches DB_CYCLES-1, the debounced level takes the synchronized value.
  - Rising edge of the debounced level gives a one-cycle press pulse. Releases generate nothing.
- Simultaneous press pulses in one cycle:
  - Only the highest priority acts: set > next > inc. The others are discarded.
- States: RUN, SET.
  - RUN → SET on set press: centiseconds cleared to 00, cursor = 0, divider cleared.
  - SET → RUN on set press: divider cleared, counting resumes. First tick comes TICK_DIV cycles after the transition.
- RUN:
  - Divider counts 0..TICK_DIV-1; the tick fires at TICK_DIV-1.
  - Each tick increments the time with BCD carry chain cc 99→00, ss 59→00, mm 59→00, hh 23→00.
  - day_wrap pulses on the same edge that digits goes from 23:59:59.99 to 00:00:00.00.
  - next and inc presses are ignored.
- SET:
  - No ticks.
  - next: cursor 0→1→2→0.
  - inc: selected field +1 with wrap (hh 23→00, mm 59→00, ss 59→00) and no carry into other fields.
  - inc never asserts day_wrap.
- Invariant: every nibble is a legal BCD digit within its field range at all times. Hour tens 2 implies hour ones ≤ 3.

## Timing
- Button latency: raw input goes high and stays high before edge N. The action is visible on outputs after edge N+2+DB_CYCLES+1 (2 sync, DB_CYCLES stable, 1 state update).
- Glitches shorter than DB_CYCLES cycles produce no pulse.
- Tick: digits update on the edge where divider = TICK_DIV-1. Period is exactly TICK_DIV cycles.
- Tick and press in the same cycle while in RUN: the set press wins. Mode goes to SET and the tick is dropped. A dropped tick does not set day_wrap.
- Reset asserted mid-operation: all outputs return to reset values immediately, regardless of clk.
- All outputs are registered; no combinational path from inputs.

## Structure
- Shared package holds:
  - cursor field codes (FLD_HH=0, FLD_MM=1, FLD_SS=2);
  - digit bit-slice position constants;
  - BCD field limits (23, 59, 99);
  - RUN/SET state encoding.
  - The scanner uses the same slice constants.
- One sub-module, `btn_debounce` (sync + counter + rise-pulse, parameter DB_CYCLES), is instantiated three times.
- Time counter, divider and FSM are in the top of this block.

## Test plan
Use DB_CYCLES=4, TICK_DIV=5 throughout.
- **Reset:** release reset → digits=0, set_mode=0, cursor=0. After 5 clk, digits=32'h0000_0001.
- **Rollover:** preload 23:59:59.98 via SET edits plus ticks. Two ticks → 32'h0000_0000 and a single-cycle day_wrap. No day_wrap on the preceding tick.
- **Edit:**
  - set press; 3× next; 2× inc → hours=02, cursor=0.
  - next; inc ×60 → minutes back at 00, hours unchanged.
  - set press → RUN; first tick 5 cycles later.
- **Bounce:** pulse btn_inc high for 3 cycles, repeatedly, in SET → no change. Hold 10 cycles → exactly one increment at the N+7 edge.
- **Priority:** btn_set and btn_next raised on the same cycle in RUN → only the mode change, cursor stays 0. Raising btn_set on a tick edge → tick dropped, cc reads 00.
- **Async reset:** assert reset mid-SET with digits=12:34:56.00 → all outputs 0 without a clk edge.

Source files
------------

// File: rtl/bcd_time_writer_pkg.sv
// Shared definitions for the packed BCD time word: field codes, slice positions,
// field limits and the run/set mode encoding.
package bcd_time_writer_pkg;

    typedef enum logic [0:0] {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } mode_e;

    localparam logic [1:0] FLD_HH = 2'd0;
    localparam logic [1:0] FLD_MM = 2'd1;
    localparam logic [1:0] FLD_SS = 2'd2;

    // Each field is a two-digit BCD byte; these are the byte LSB positions in digits.
    localparam int unsigned FLD_W  = 8;
    localparam int unsigned HH_LSB = 24;
    localparam int unsigned MM_LSB = 16;
    localparam int unsigned SS_LSB = 8;
    localparam int unsigned CC_LSB = 0;

    localparam logic [7:0] HH_MAX = 8'h23;
    localparam logic [7:0] MM_MAX = 8'h59;
    localparam logic [7:0] SS_MAX = 8'h59;
    localparam logic [7:0] CC_MAX = 8'h99;

    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] lim);
        logic [7:0] res;
        if (val == lim) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_time_writer_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted press (releases produce nothing).
module btn_debounce
    import bcd_time_writer_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_r;
    logic          level_r;
    logic [CW-1:0] cnt_r;
    logic          db_r;
    logic          press_r;
    logic          lvl_s;
    logic          stable_s;

    assign lvl_s    = sync_r[1];
    assign stable_s = (lvl_s == level_r) && (cnt_r == CNT_LAST);

    // Synchronize, time the stable level, and accept it once it has held long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_r  <= 2'b00;
            level_r <= 1'b0;
            cnt_r   <= '0;
            db_r    <= 1'b0;
            press_r <= 1'b0;
        end else begin
            sync_r  <= {sync_r[0], btn};
            level_r <= lvl_s;
            if (lvl_s != level_r) begin
                cnt_r <= '0;
            end else if (cnt_r != CNT_LAST) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            if (stable_s) begin
                db_r <= lvl_s;
            end else begin
                db_r <= db_r;
            end
            press_r <= stable_s && lvl_s && !db_r;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/bcd_time_writer.sv
// 100 Hz time-of-day counter producing the packed HH:MM:SS.cc BCD word, with a
// three-button run/set editor. All outputs come straight from registers.
module bcd_time_writer
    import bcd_time_writer_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned TICK_DIV  = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_set,
    input  logic        btn_next,
    input  logic        btn_inc,
    output logic [31:0] digits,
    output logic        set_mode,
    output logic [1:0]  cursor,
    output logic        day_wrap
);

    localparam int unsigned DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    mode_e         state_r, state_s;
    logic [1:0]    cursor_r, cursor_s;
    logic [31:0]   digits_r, digits_s;
    logic [DW-1:0] div_r, div_s;
    logic          wrap_r, wrap_s;
    logic          set_p_s, next_p_s, inc_p_s;
    logic [7:0]    hh_s, mm_s, ss_s, cc_s;
    logic          c_ss_s, c_mm_s, c_hh_s, tick_wrap_s;
    logic [31:0]   tick_digits_s;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set  (.clk(clk), .reset(reset), .btn(btn_set),  .press(set_p_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (.clk(clk), .reset(reset), .btn(btn_next), .press(next_p_s));
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc  (.clk(clk), .reset(reset), .btn(btn_inc),  .press(inc_p_s));

    assign hh_s = digits_r[HH_LSB +: FLD_W];
    assign mm_s = digits_r[MM_LSB +: FLD_W];
    assign ss_s = digits_r[SS_LSB +: FLD_W];
    assign cc_s = digits_r[CC_LSB +: FLD_W];

    // Carry ripples upward only while every lower field sits at its limit.
    assign c_ss_s      = (cc_s == CC_MAX);
    assign c_mm_s      = c_ss_s && (ss_s == SS_MAX);
    assign c_hh_s      = c_mm_s && (mm_s == MM_MAX);
    assign tick_wrap_s = c_hh_s && (hh_s == HH_MAX);
    assign tick_digits_s = {c_hh_s ? bcd_inc(hh_s, HH_MAX) : hh_s,
                            c_mm_s ? bcd_inc(mm_s, MM_MAX) : mm_s,
                            c_ss_s ? bcd_inc(ss_s, SS_MAX) : ss_s,
                            bcd_inc(cc_s, CC_MAX)};

    // Mode FSM, divider and time update; set beats next beats inc, and set beats a tick.
    always_comb begin
        state_s  = state_r;
        cursor_s = cursor_r;
        digits_s = digits_r;
        div_s    = div_r;
        wrap_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (set_p_s) begin
                    state_s  = ST_SET;
                    cursor_s = FLD_HH;
                    digits_s[CC_LSB +: FLD_W] = 8'h00;
                    div_s    = '0;
                end else if (div_r == DIV_LAST) begin
                    div_s    = '0;
                    digits_s = tick_digits_s;
                    wrap_s   = tick_wrap_s;
                end else begin
                    div_s = div_r + DW'(1);
                end
            end
            ST_SET: begin
                div_s = '0;
                if (set_p_s) begin
                    state_s = ST_RUN;
                end else if (next_p_s) begin
                    case (cursor_r)
                        FLD_HH:  cursor_s = FLD_MM;
                        FLD_MM:  cursor_s = FLD_SS;
                        default: cursor_s = FLD_HH;
                    endcase
                end else if (inc_p_s) begin
                    case (cursor_r)
                        FLD_HH:  digits_s[HH_LSB +: FLD_W] = bcd_inc(hh_s, HH_MAX);
                        FLD_MM:  digits_s[MM_LSB +: FLD_W] = bcd_inc(mm_s, MM_MAX);
                        FLD_SS:  digits_s[SS_LSB +: FLD_W] = bcd_inc(ss_s, SS_MAX);
                        default: digits_s = digits_r;
                    endcase
                end else begin
                    state_s = ST_SET;
                end
            end
            default: begin
                state_s  = ST_RUN;
                cursor_s = FLD_HH;
                digits_s = 32'h0000_0000;
                div_s    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_RUN;
            cursor_r <= FLD_HH;
            digits_r <= 32'h0000_0000;
            div_r    <= '0;
            wrap_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cursor_r <= cursor_s;
            digits_r <= digits_s;
            div_r    <= div_s;
            wrap_r   <= wrap_s;
        end
    end

    assign digits   = digits_r;
    assign set_mode = (state_r == ST_SET);
    assign cursor   = cursor_r;
    assign day_wrap = wrap_r;

endmodule

// File: tb/tb_bcd_time_writer.sv
// Bench for bcd_time_writer: a time-of-day model in plain centisecond arithmetic,
// a per-cycle output comparison, and directed button sequences with literal checks.
module tb_bcd_time_writer;

    localparam int TICK = 5;
    localparam int LAT  = 8;
    localparam int DAY  = 8640000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        btn_set = 1'b0, btn_next = 1'b0, btn_inc = 1'b0;
    logic [31:0] digits;
    logic        set_mode;
    logic [1:0]  cursor;
    logic        day_wrap;

    int n_checks = 0;
    int n_pass   = 0;
    int ed       = 0;
    int m_t = 0, m_cur = 0, m_nt = -1;
    bit m_set = 1'b0, m_wrap = 1'b0;
    int q_set[$], q_next[$], q_inc[$];

    bcd_time_writer #(.DB_CYCLES(4), .TICK_DIV(TICK)) dut (
        .clk(clk), .reset(rst_n), .btn_set(btn_set), .btn_next(btn_next),
        .btn_inc(btn_inc), .digits(digits), .set_mode(set_mode),
        .cursor(cursor), .day_wrap(day_wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int t);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int bump(input int t, input int fld);
        int h, m, s, c;
        h = t / 360000;
        m = (t / 6000) % 60;
        s = (t / 100) % 60;
        c = t % 100;
        if (fld == 0) h = (h + 1) % 24;
        else if (fld == 1) m = (m + 1) % 60;
        else s = (s + 1) % 60;
        return ((h * 60 + m) * 60 + s) * 100 + c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, ed);
    endtask

    // Reference model: presses take effect LAT edges after the raw line rises.
    always @(posedge clk or negedge rst_n) begin : model_b
        int cur, t_n, cur_n, nt_n;
        bit sp, np, ip, set_n, wrap_n;
        if (!rst_n) begin
            m_t <= 0; m_set <= 1'b0; m_cur <= 0; m_wrap <= 1'b0; m_nt <= -1;
            q_set.delete(); q_next.delete(); q_inc.delete();
        end else begin
            cur = ed + 1;
            ed <= cur;
            sp = 1'b0; np = 1'b0; ip = 1'b0;
            if (q_set.size() != 0 && q_set[0] == cur) begin sp = 1'b1; void'(q_set.pop_front()); end
            if (q_next.size() != 0 && q_next[0] == cur) begin np = 1'b1; void'(q_next.pop_front()); end
            if (q_inc.size() != 0 && q_inc[0] == cur) begin ip = 1'b1; void'(q_inc.pop_front()); end
            t_n = m_t; set_n = m_set; cur_n = m_cur; wrap_n = 1'b0;
            nt_n = (m_nt < 0) ? cur + TICK - 1 : m_nt;
            if (!m_set) begin
                if (sp) begin
                    set_n = 1'b1; cur_n = 0; t_n = m_t - (m_t % 100);
                end else if (cur == nt_n) begin
                    t_n = (m_t + 1) % DAY; wrap_n = (t_n == 0); nt_n = cur + TICK;
                end
            end else begin
                if (sp) begin
                    set_n = 1'b0; nt_n = cur + TICK;
                end else if (np) begin
                    cur_n = (m_cur + 1) % 3;
                end else if (ip) begin
                    t_n = bump(m_t, m_cur);
                end
            end
            m_t <= t_n; m_set <= set_n; m_cur <= cur_n; m_wrap <= wrap_n; m_nt <= nt_n;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("digits", digits, to_bcd(m_t));
        chk("set_mode", {31'd0, set_mode}, {31'd0, m_set});
        chk("cursor", {30'd0, cursor}, 32'(m_cur));
        chk("day_wrap", {31'd0, day_wrap}, {31'd0, m_wrap});
    end

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (ed < target && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (ed != target) begin
            n_checks++;
            $display("FAIL wait_until: at edge %0d wanted %0d", ed, target);
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold, output int act);
        act = ed + LAT;
        if (hold >= 8) begin
            if (mask[2]) q_set.push_back(act);
            if (mask[1]) q_next.push_back(act);
            if (mask[0]) q_inc.push_back(act);
        end
        btn_set = mask[2]; btn_next = mask[1]; btn_inc = mask[0];
        repeat (hold) @(posedge clk);
        #1;
        btn_set = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic inc_n(input int n);
        int a;
        for (int i = 0; i < n; i++) press(3'b001, 10, a);
    endtask

    task automatic next1;
        int a;
        press(3'b010, 10, a);
    endtask

    initial begin
        int a, e0, h, m, s;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        e0 = ed;
        chk("reset_digits", digits, 32'h0000_0000);
        chk("reset_mode", {31'd0, set_mode}, 32'd0);
        chk("reset_cursor", {30'd0, cursor}, 32'd0);
        wait_until(e0 + 4);
        chk("pre_first_tick", digits, 32'h0000_0000);
        wait_until(e0 + 5);
        chk("first_tick", digits, 32'h0000_0001);

        // Edit hours and minutes
        press(3'b100, 10, a);
        next1; next1; next1;
        inc_n(2);
        chk("edit_hours", {24'd0, digits[31:24]}, 32'h02);
        chk("edit_cursor", {30'd0, cursor}, 32'd0);
        next1;
        inc_n(60);
        chk("edit_min_wrap", {16'd0, digits[31:16]}, 32'h0200);

        // Back to RUN; first tick exactly TICK edges after the mode change
        btn_set = 1'b1; a = ed + LAT; q_set.push_back(a);
        wait_until(a + 2); btn_set = 1'b0;
        wait_until(a + 4);
        chk("resume_no_tick", digits, 32'h0200_0000);
        chk("resume_mode", {31'd0, set_mode}, 32'd0);
        wait_until(a + 5);
        chk("resume_tick", digits, 32'h0200_0001);
        wait_until(a + 10);

        // Bounce: short pulses ignored, a long hold gives one increment
        press(3'b100, 10, a);
        for (int i = 0; i < 4; i++) press(3'b001, 3, a);
        chk("bounce_hours", {24'd0, digits[31:24]}, 32'h02);
        btn_inc = 1'b1; a = ed + LAT; q_inc.push_back(a);
        wait_until(a - 1);
        chk("hold_before", {24'd0, digits[31:24]}, 32'h02);
        wait_until(a);
        chk("hold_at_edge", {24'd0, digits[31:24]}, 32'h03);
        wait_until(a + 2); btn_inc = 1'b0;
        wait_until(a + 10);

        // Rollover from 23:59:59.00 through ticks
        h = m_t / 360000;         inc_n((23 - h + 24) % 24); next1;
        m = (m_t / 6000) % 60;    inc_n((59 - m + 60) % 60); next1;
        s = (m_t / 100) % 60;     inc_n((59 - s + 60) % 60);
        chk("preload", digits, 32'h2359_5900);
        press(3'b100, 10, a);
        wait_until(a + 98 * TICK);
        chk("roll_98", digits, 32'h2359_5998);
        chk("roll_98_wrap", {31'd0, day_wrap}, 32'd0);
        wait_until(a + 99 * TICK);
        chk("roll_99", digits, 32'h2359_5999);
        chk("roll_99_wrap", {31'd0, day_wrap}, 32'd0);
        wait_until(a + 100 * TICK);
        chk("roll_zero", digits, 32'h0000_0000);
        chk("roll_wrap", {31'd0, day_wrap}, 32'd1);
        wait_until(a + 100 * TICK + 1);
        chk("roll_wrap_end", {31'd0, day_wrap}, 32'd0);

        // Priority: set together with next only changes mode
        press(3'b110, 10, a);
        chk("prio_mode", {31'd0, set_mode}, 32'd1);
        chk("prio_cursor", {30'd0, cursor}, 32'd0);
        press(3'b100, 10, a);
        wait_until(a + 12);
        btn_set = 1'b1; q_set.push_back(a + 20);
        wait_until(a + 19);
        chk("pre_drop", digits, 32'h0000_0003);
        wait_until(a + 20);
        chk("tick_dropped", digits, 32'h0000_0000);
        chk("drop_mode", {31'd0, set_mode}, 32'd1);
        chk("drop_wrap", {31'd0, day_wrap}, 32'd0);
        wait_until(a + 22); btn_set = 1'b0;
        wait_until(a + 30);

        // Async reset from 12:34:56.00 in set mode
        h = m_t / 360000;         inc_n((12 - h + 24) % 24); next1;
        m = (m_t / 6000) % 60;    inc_n((34 - m + 60) % 60); next1;
        s = (m_t / 100) % 60;     inc_n((56 - s + 60) % 60);
        chk("preset_time", digits, 32'h1234_5600);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_digits", digits, 32'h0000_0000);
        chk("arst_mode", {31'd0, set_mode}, 32'd0);
        chk("arst_cursor", {30'd0, cursor}, 32'd0);
        chk("arst_wrap", {31'd0, day_wrap}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
